// File: rtl/keypad_pkg.sv
// Shared types and the row/column to key-code map for the 4x3 keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  localparam int         NUM_ROWS = 4;
  localparam int         NUM_COLS = 3;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  // Rows 0-2 hold digits 1-9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'd0;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the idle-high keypad rows; resets to the idle level.
module keypad_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, row debounce, one press event per key press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [9:0] key_onehot,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 3 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("keypad_scanner: invalid parameter values");
  end

  state_t        state;
  logic [3:0]    rs;
  logic [1:0]    col_idx, next_col, cand_row, cand_col, low_row;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;
  logic [3:0]    cand_code;
  logic [9:0]    cand_onehot;

  keypad_sync #(.W(NUM_ROWS)) u_sync (.clk(clk), .rst(rst), .d(key_row), .q(rs));

  always_comb begin
    low_row = 2'd0;
    for (int r = NUM_ROWS - 1; r >= 0; r--)
      if (!rs[r]) low_row = 2'(r);
  end

  assign next_col    = (col_idx == 2'(NUM_COLS - 1)) ? 2'd0 : col_idx + 2'd1;
  assign cand_code   = key_map(cand_row, cand_col);
  assign cand_onehot = (cand_code <= 4'd9) ? (10'b1 << cand_code) : 10'b0;

`ifdef KEYPAD_REPEAT_EN
  localparam int HW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  logic [HW-1:0] hold_cnt;
  logic          repeating;
  logic [HW-1:0] hold_last;
  assign hold_last = repeating ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      key_col    <= 3'b110;
      dwell      <= '0;
      deb_cnt    <= '0;
      cand_row   <= 2'd0;
      cand_col   <= 2'd0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_onehot <= 10'b0;
      key_held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      hold_cnt   <= '0;
      repeating  <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs != 4'b1111) begin
              state    <= DEBOUNCE;
              cand_row <= low_row;
              cand_col <= col_idx;
              deb_cnt  <= '0;
            end else begin
              col_idx <= next_col;
              key_col <= ~(3'b001 << next_col);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (rs[cand_row]) begin
            state   <= SCAN;
            deb_cnt <= '0;
            col_idx <= next_col;
            key_col <= ~(3'b001 << next_col);
          end else if (deb_cnt == DEB_LAST) begin
            state      <= PRESSED;
            deb_cnt    <= '0;
            key_valid  <= 1'b1;
            key_code   <= cand_code;
            key_onehot <= cand_onehot;
            key_held   <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (rs[cand_row]) begin
            state   <= RELEASE;
            deb_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
            hold_cnt  <= '0;
            repeating <= 1'b0;
          end else if (hold_cnt == hold_last) begin
            hold_cnt  <= '0;
            repeating <= 1'b1;
            key_valid <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        RELEASE: begin
          // A low blip returns to PRESSED silently; only a full release rearms the scan.
          if (!rs[cand_row]) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state      <= SCAN;
            deb_cnt    <= '0;
            key_onehot <= 10'b0;
            key_held   <= 1'b0;
            col_idx    <= next_col;
            key_col    <= ~(3'b001 << next_col);
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule
